// File: rtl/vcii_stim_gen.sv
// Waveform generator (DC/saw/triangle/square) feeding a 1-bit first-order sigma-delta stream
// that an external RC filter turns into the VCII y input voltage.
module vcii_stim_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] level,
  input  logic [3:0]       step,
  input  logic [DIV_W-1:0] rate_div,
  output logic             ds_out,
  output logic [WIDTH-1:0] code,
  output logic             upd,
  output logic             dir
);

  typedef enum logic [1:0] {
    MODE_DC  = 2'b00,
    MODE_SAW = 2'b01,
    MODE_TRI = 2'b10,
    MODE_SQR = 2'b11
  } mode_e;

  mode_e            mode_q, mode_n;
  logic [DIV_W-1:0] cnt_q, cnt_n;
  logic [WIDTH-1:0] acc_q, acc_n;
  logic [WIDTH-1:0] code_n;
  logic             dir_n, upd_n, ds_n;

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   sd_sum;
  logic             tick;

  assign step_ext = {{(WIDTH-4){1'b0}}, step};
  assign up_sum   = {1'b0, code} + {1'b0, step_ext};
  assign sd_sum   = {1'b0, acc_q} + {1'b0, code};
  assign tick     = (cnt_q == rate_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      code   <= '0;
      dir    <= 1'b1;
      upd    <= 1'b0;
      ds_out <= 1'b0;
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= mode_e'(mode);
    end else begin
      code   <= code_n;
      dir    <= dir_n;
      upd    <= upd_n;
      ds_out <= ds_n;
      acc_q  <= acc_n;
      cnt_q  <= cnt_n;
      mode_q <= mode_n;
    end
  end

  always_comb begin
    mode_n = mode_q;
    cnt_n  = cnt_q;
    acc_n  = acc_q;
    code_n = code;
    dir_n  = dir;
    upd_n  = 1'b0;
    ds_n   = 1'b0;

    if (en) begin
      // The modulator runs on the code registered at the start of this cycle.
      ds_n  = sd_sum[WIDTH];
      acc_n = sd_sum[WIDTH-1:0];

      if (mode_e'(mode) != mode_q) begin
        // A mode switch restarts the waveform and swallows any coincident tick.
        mode_n = mode_e'(mode);
        code_n = '0;
        dir_n  = 1'b1;
        cnt_n  = '0;
      end else begin
        cnt_n = tick ? '0 : cnt_q + DIV_W'(1);
        case (mode_q)
          MODE_DC: code_n = level;
          MODE_SAW: begin
            if (tick) begin
              upd_n  = 1'b1;
              code_n = (up_sum > {1'b0, level}) ? '0 : up_sum[WIDTH-1:0];
            end
          end
          MODE_TRI: begin
            if (tick) begin
              upd_n = 1'b1;
              if (dir) begin
                if (up_sum >= {1'b0, level}) begin
                  code_n = level;
                  dir_n  = 1'b0;
                end else begin
                  code_n = up_sum[WIDTH-1:0];
                end
              end else begin
                if (code <= step_ext) begin
                  code_n = '0;
                  dir_n  = 1'b1;
                end else begin
                  code_n = code - step_ext;
                end
              end
            end
          end
          MODE_SQR: begin
            if (tick) begin
              upd_n  = 1'b1;
              code_n = (code == '0) ? level : '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vcii_stim_gen.sv
// Directed bench for vcii_stim_gen: DC density, sawtooth, triangle, square with enable freeze,
// mode switch on a tick, and mid-run reset clearing the modulator.
module tb_vcii_stim_gen;
  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] mode;
  logic [7:0] level;
  logic [3:0] step;
  logic [7:0] rate_div;
  logic       ds_out;
  logic [7:0] code;
  logic       upd, dir;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vcii_stim_gen #(.WIDTH(8), .DIV_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .level    (level),
    .step     (step),
    .rate_div (rate_div),
    .ds_out   (ds_out),
    .code     (code),
    .upd      (upd),
    .dir      (dir)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int unsigned ones, upds;
  logic [7:0] saw_exp [7] = '{8'd6, 8'd12, 8'd18, 8'd0, 8'd6, 8'd12, 8'd18};
  logic [7:0] tri_code[10] = '{8'd4, 8'd8, 8'd10, 8'd6, 8'd2, 8'd0, 8'd4, 8'd8, 8'd10, 8'd6};
  logic       tri_dir [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; level = 8'd64; step = 4'd0; rate_div = 8'd0;
    cyc(); cyc();
    chk("rst_code", code, 0);
    chk("rst_dir", dir, 1);
    chk("rst_upd", upd, 0);
    chk("rst_ds", ds_out, 0);

    // DC: first enabled edge loads the code, then 256 cycles give exactly 64 ones.
    rst = 1'b0; en = 1'b1;
    cyc();
    chk("dc_code_first", code, 64);
    chk("dc_upd_first", upd, 0);
    ones = 0; upds = 0;
    repeat (256) begin
      cyc();
      ones += ds_out;
      upds += upd;
    end
    chk("dc_density", ones, 64);
    chk("dc_upd_count", upds, 0);
    chk("dc_code_end", code, 64);

    // Sawtooth: mode-change cycle, then a new value every 4 cycles.
    mode = 2'b01; level = 8'd20; step = 4'd6; rate_div = 8'd3;
    cyc();
    chk("saw_enter_code", code, 0);
    chk("saw_enter_upd", upd, 0);
    for (int i = 0; i < 7; i++) begin
      repeat (3) begin
        cyc();
        chk("saw_idle_upd", upd, 0);
      end
      cyc();
      chk("saw_upd", upd, 1);
      chk("saw_code", code, saw_exp[i]);
    end
    repeat (3) begin
      cyc();
      chk("saw_hold_code", code, 18);
    end

    // Switch to triangle exactly on a sawtooth tick.
    mode = 2'b10; level = 8'd10; step = 4'd4; rate_div = 8'd0;
    cyc();
    chk("sw_code", code, 0);
    chk("sw_dir", dir, 1);
    chk("sw_upd", upd, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("tri_code", code, tri_code[i]);
      chk("tri_dir", dir, tri_dir[i]);
      chk("tri_upd", upd, 1);
    end

    // Reset while descending; DC 255 afterwards exposes any leftover accumulator.
    rst = 1'b1; mode = 2'b00; level = 8'd255;
    cyc();
    chk("mr_code", code, 0);
    chk("mr_dir", dir, 1);
    chk("mr_upd", upd, 0);
    chk("mr_ds", ds_out, 0);
    rst = 1'b0;
    cyc();
    chk("mr_code_dc", code, 255);
    chk("mr_ds_0", ds_out, 0);
    cyc();
    chk("mr_ds_1", ds_out, 0);
    cyc();
    chk("mr_ds_2", ds_out, 1);

    // Square with rate_div=1, enable dropped for 5 cycles while code=200.
    mode = 2'b11; level = 8'd200; rate_div = 8'd1;
    cyc();
    chk("sq_enter_code", code, 0);
    chk("sq_enter_upd", upd, 0);
    chk("sq_enter_ds", ds_out, 1);
    cyc();
    chk("sq_f1_code", code, 0);
    chk("sq_f1_upd", upd, 0);
    cyc();
    chk("sq_f2_code", code, 200);
    chk("sq_f2_upd", upd, 1);
    cyc();
    chk("sq_f3_code", code, 200);
    chk("sq_f3_upd", upd, 0);
    chk("sq_f3_ds", ds_out, 1);
    en = 1'b0;
    repeat (5) begin
      cyc();
      chk("sq_frz_code", code, 200);
      chk("sq_frz_ds", ds_out, 0);
      chk("sq_frz_upd", upd, 0);
    end
    en = 1'b1;
    cyc();
    chk("sq_res_code0", code, 0);
    chk("sq_res_upd0", upd, 1);
    chk("sq_res_ds0", ds_out, 1);
    cyc();
    chk("sq_res_code1", code, 0);
    chk("sq_res_upd1", upd, 0);
    chk("sq_res_ds1", ds_out, 0);
    cyc();
    chk("sq_res_code2", code, 200);
    chk("sq_res_upd2", upd, 1);
    cyc();
    chk("sq_res_ds3", ds_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
